bist_lfsr_misr: RTL and testbench

//  BIST datapath stage sitting directly downstream of the BIST controller; consumes its init/running/toggle/finish strobes.

---
 rtl/bist_pkg.sv | 34 +++
 rtl/bist_galois_reg.sv | 53 +++++
 rtl/bist_lfsr_misr.sv | 168 ++++++++++++++++
 tb/tb_bist_lfsr_misr.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST pattern-generation / response-compaction
// datapath: the controller-facing state encoding, default Galois tap masks,
// and the single-step Galois shift used by both the LFSR and the MISR.
// -----------------------------------------------------------------------------
package bist_pkg;

    // States of the datapath's view of a BIST session.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RUN     = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } bist_state_t;

    // Widest register the shared step function can handle.
    localparam int GALOIS_MAX_W = 32;

    localparam logic [7:0] DEFAULT_LFSR_TAPS = 8'hB8;
    localparam logic [7:0] DEFAULT_MISR_TAPS = 8'hB8;

    // One right-shifting Galois step. Operands are zero-extended to the
    // maximum width, so the zero shifted in at the top lands in the correct
    // bit for any narrower register; callers truncate the result back.
    function automatic logic [GALOIS_MAX_W-1:0] galois_step(
        input logic [GALOIS_MAX_W-1:0] value,
        input logic [GALOIS_MAX_W-1:0] taps
    );
        galois_step = (value >> 1) ^ (value[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/bist_galois_reg.sv
// -----------------------------------------------------------------------------
// bist_galois_reg
// Galois shift register with parallel load and serial-parallel data fold-in.
// With i_din tied to zero it is a pattern-generating LFSR; with i_din fed
// from the circuit under test it is a MISR compacting responses.
//
// Ports
//   i_clk       clock, rising edge
//   i_reset     asynchronous active-high reset, loads RESET_VAL
//   i_load      synchronous load of i_load_val (wins over i_en)
//   i_load_val  value loaded when i_load is high
//   i_en        advance one Galois step and fold in i_din
//   i_din       data XORed into the stepped value
//   o_value     current register contents
// -----------------------------------------------------------------------------
module bist_galois_reg
    import bist_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEFAULT_LFSR_TAPS),
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_value
);

    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_next;

    // Next value when enabled: one Galois step of the current contents with
    // the incoming data folded in afterwards.
    assign w_next = WIDTH'(galois_step(GALOIS_MAX_W'(r_value), GALOIS_MAX_W'(TAPS))) ^ i_din;

    // Load takes priority so a restart in the same cycle as an enable
    // always starts from the load value.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_value <= RESET_VAL;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_en) begin
            r_value <= w_next;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/bist_lfsr_misr.sv
// -----------------------------------------------------------------------------
// bist_lfsr_misr
// BIST datapath stage driven by the BIST controller strobes. Generates
// pseudo-random vectors with a Galois LFSR, compacts the CUT responses into a
// MISR signature, and after finish compares the signature against a golden
// value, holding pass/fail until the next init.
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous active-high reset
//   init           controller init strobe, restarts the session
//   running        one vector applied and compacted per high cycle
//   toggle         inverts the vector presented to the CUT
//   finish         controller finish strobe, starts the comparison
//   cut_resp       CUT response to test_vector, same cycle
//   test_vector    vector to the CUT (LFSR, optionally inverted)
//   vector_valid   vector is being applied this cycle
//   pattern_count  vectors applied since init, saturating
//   signature      current MISR contents
//   result_valid   pass/fail are meaningful
//   pass           signature matched the golden value
//   fail           signature did not match
// -----------------------------------------------------------------------------
module bist_lfsr_misr
    import bist_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] LFSR_SEED  = 8'h01,
    parameter logic [WIDTH-1:0] LFSR_TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] MISR_TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] GOLDEN_SIG = 8'h5C,
    parameter int               CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             running,
    input  logic             toggle,
    input  logic             finish,
    input  logic [WIDTH-1:0] cut_resp,
    output logic [WIDTH-1:0] test_vector,
    output logic             vector_valid,
    output logic [CNT_W-1:0] pattern_count,
    output logic [WIDTH-1:0] signature,
    output logic             result_valid,
    output logic             pass,
    output logic             fail
);

    bist_state_t      r_state;
    bist_state_t      w_next_state;
    logic             w_active;
    logic             w_step;
    logic [WIDTH-1:0] w_lfsr;
    logic [WIDTH-1:0] w_misr;
    logic [CNT_W-1:0] r_count;
    logic             r_pass;
    logic             r_fail;

    // Vectors are applied only in ARMED/RUN, and init wins over running so
    // a restart never also steps the registers it is reloading.
    assign w_active = (r_state == ARMED) || (r_state == RUN);
    assign w_step   = running && w_active && !init;

    // Pattern generator: free-running Galois LFSR, reseeded on init.
    bist_galois_reg #(
        .WIDTH     (WIDTH),
        .TAPS      (LFSR_TAPS),
        .RESET_VAL (LFSR_SEED)
    ) u_lfsr (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_load     (init),
        .i_load_val (LFSR_SEED),
        .i_en       (w_step),
        .i_din      ('0),
        .o_value    (w_lfsr)
    );

    // Response compactor: same step, with the CUT response folded in.
    bist_galois_reg #(
        .WIDTH     (WIDTH),
        .TAPS      (MISR_TAPS),
        .RESET_VAL ('0)
    ) u_misr (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_load     (init),
        .i_load_val ('0),
        .i_en       (w_step),
        .i_din      (cut_resp),
        .o_value    (w_misr)
    );

    // State register for the session sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Session sequencing: init restarts from anywhere; finish from ARMED or
    // RUN takes precedence over the ARMED->RUN move; COMPARE lasts one cycle;
    // DONE and IDLE wait for init.
    always_comb begin
        w_next_state = r_state;
        if (init) begin
            w_next_state = ARMED;
        end else begin
            case (r_state)
                ARMED: begin
                    if (finish) begin
                        w_next_state = COMPARE;
                    end else if (running) begin
                        w_next_state = RUN;
                    end
                end
                RUN: begin
                    if (finish) begin
                        w_next_state = COMPARE;
                    end
                end
                COMPARE: w_next_state = DONE;
                default: ;
            endcase
        end
    end

    // Applied-pattern counter; sticks at all-ones rather than wrapping so a
    // long run never looks like a short one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (init) begin
            r_count <= '0;
        end else if (w_step && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Verdict registers: captured in the single COMPARE cycle and then held
    // through DONE; cleared by init so no stale result survives a restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (init) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (r_state == COMPARE) begin
            r_pass <= (w_misr == GOLDEN_SIG);
            r_fail <= (w_misr != GOLDEN_SIG);
        end
    end

    // Toggle inverts only what the CUT sees; the LFSR keeps stepping on its
    // own uninverted value.
    assign test_vector   = w_lfsr ^ {WIDTH{toggle}};
    assign vector_valid  = running && w_active;
    assign pattern_count = r_count;
    assign signature     = w_misr;
    assign result_valid  = (r_state == DONE);
    assign pass          = r_pass;
    assign fail          = r_fail;

endmodule

// File: tb/tb_bist_lfsr_misr.sv
// -----------------------------------------------------------------------------
// tb_bist_lfsr_misr
// Self-checking bench for bist_lfsr_misr: directed session scenarios followed
// by randomized controller strobes, all compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_bist_lfsr_misr;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int SEED  = 'h01;
    localparam int LTAPS = 'hB8;
    localparam int MTAPS = 'hB8;
    localparam int GOLD  = 'h5C;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam int M_IDLE    = 0;
    localparam int M_ARMED   = 1;
    localparam int M_RUN     = 2;
    localparam int M_COMPARE = 3;
    localparam int M_DONE    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             init = 1'b0;
    logic             running = 1'b0;
    logic             toggle = 1'b0;
    logic             finish = 1'b0;
    logic [WIDTH-1:0] cut_resp = '0;
    logic [WIDTH-1:0] test_vector;
    logic             vector_valid;
    logic [CNT_W-1:0] pattern_count;
    logic [WIDTH-1:0] signature;
    logic             result_valid;
    logic             pass;
    logic             fail;

    int checks = 0;
    int failures = 0;

    int mState;
    int mLfsr;
    int mMisr;
    int mCount;
    int mPass;
    int mFail;

    logic [WIDTH-1:0] lastVec;

    bist_lfsr_misr #(
        .WIDTH      (WIDTH),
        .LFSR_SEED  (8'h01),
        .LFSR_TAPS  (8'hB8),
        .MISR_TAPS  (8'hB8),
        .GOLDEN_SIG (8'h5C),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .running       (running),
        .toggle        (toggle),
        .finish        (finish),
        .cut_resp      (cut_resp),
        .test_vector   (test_vector),
        .vector_valid  (vector_valid),
        .pattern_count (pattern_count),
        .signature     (signature),
        .result_valid  (result_valid),
        .pass          (pass),
        .fail          (fail)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected normal end");
        $fatal(1, "[TB] watchdog expired");
    end

    // The one place comparisons are counted and reported.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Model of the session after reset: nothing started, nothing reported.
    task automatic modelReset();
        mState = M_IDLE;
        mLfsr  = SEED;
        mMisr  = 0;
        mCount = 0;
        mPass  = 0;
        mFail  = 0;
    endtask

    // One Galois step written as plain arithmetic: halve, and if the value
    // was odd fold the tap mask in.
    function automatic int galoisNext(input int v, input int taps);
        return (v / 2) ^ (((v % 2) == 1) ? taps : 0);
    endfunction

    function automatic int modelVec(input logic t);
        return (mLfsr ^ (t ? 'hFF : 0)) & 'hFF;
    endfunction

    // What one clock edge does to the session, given the strobes seen there.
    task automatic modelStep(input logic i, input logic r, input logic f, input int resp);
        if (i) begin
            mLfsr  = SEED;
            mMisr  = 0;
            mCount = 0;
            mPass  = 0;
            mFail  = 0;
            mState = M_ARMED;
        end else if (mState == M_ARMED || mState == M_RUN) begin
            if (r) begin
                mLfsr  = galoisNext(mLfsr, LTAPS);
                mMisr  = galoisNext(mMisr, MTAPS) ^ resp;
                mCount = (mCount < CMAX) ? mCount + 1 : CMAX;
                mState = M_RUN;
            end
            if (f) mState = M_COMPARE;
        end else if (mState == M_COMPARE) begin
            mPass  = (mMisr == GOLD) ? 1 : 0;
            mFail  = 1 - mPass;
            mState = M_DONE;
        end
    endtask

    // Compare every visible output against the model's present view.
    task automatic compareAll();
        logic expValid;
        expValid = running && (mState == M_ARMED || mState == M_RUN);
        checkOutput("test_vector", 32'(test_vector), 32'(modelVec(toggle)));
        checkOutput("vector_valid", 32'(vector_valid), 32'(expValid));
        checkOutput("pattern_count", 32'(pattern_count), 32'(mCount));
        checkOutput("signature", 32'(signature), 32'(mMisr));
        checkOutput("result_valid", 32'(result_valid), 32'(mState == M_DONE));
        checkOutput("pass", 32'(pass), 32'(mPass));
        checkOutput("fail", 32'(fail), 32'(mFail));
    endtask

    // Drive one cycle of controller strobes mid-cycle, check outputs before
    // the edge, then let the model take the same edge. The CUT is modelled as
    // echoing the applied vector, optionally corrupted by respXor.
    task automatic applyStimulus(input logic i, input logic r, input logic t, input logic f,
                                 input logic [WIDTH-1:0] respXor);
        @(negedge clk);
        init     = i;
        running  = r;
        toggle   = t;
        finish   = f;
        cut_resp = WIDTH'(modelVec(t)) ^ respXor;
        #1;
        lastVec = test_vector;
        compareAll();
        @(posedge clk);
        modelStep(i, r, f, int'(cut_resp));
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic resetDut();
        @(posedge clk);
        #3;
        init    = 1'b0;
        running = 1'b0;
        toggle  = 1'b0;
        finish  = 1'b0;
        reset   = 1'b1;
        modelReset();
        #1;
        compareAll();
        #2;
        reset = 1'b0;
    endtask

    initial begin
        modelReset();
        $display("[TB] starting bist_lfsr_misr bench");

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        #1;
        compareAll();
        @(negedge clk);
        reset = 1'b0;

        // Matching responses reproduce the golden signature.
        applyStimulus(1, 0, 0, 0, 8'h00);
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("t1_vec0", 32'(lastVec), 32'h01);
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("t1_vec1", 32'(lastVec), 32'hB8);
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("t1_vec2", 32'(lastVec), 32'h5C);
        #1;
        checkOutput("t1_sig", 32'(signature), 32'h5C);
        checkOutput("t1_count", 32'(pattern_count), 32'd3);
        applyStimulus(0, 0, 0, 1, 8'h00);
        applyStimulus(0, 0, 0, 0, 8'h00);
        #1;
        checkOutput("t1_rvalid", 32'(result_valid), 32'd1);
        checkOutput("t1_pass", 32'(pass), 32'd1);
        checkOutput("t1_fail", 32'(fail), 32'd0);

        // A single flipped response bit spoils the signature.
        applyStimulus(1, 0, 0, 0, 8'h00);
        applyStimulus(0, 1, 0, 0, 8'h00);
        applyStimulus(0, 1, 0, 0, 8'h01);
        applyStimulus(0, 1, 0, 0, 8'h00);
        #1;
        checkOutput("t2_sig", 32'(signature), 32'hE4);
        applyStimulus(0, 0, 0, 1, 8'h00);
        applyStimulus(0, 0, 0, 0, 8'h00);
        #1;
        checkOutput("t2_pass", 32'(pass), 32'd0);
        checkOutput("t2_fail", 32'(fail), 32'd1);

        // Toggle inverts the applied vector but not the sequence.
        applyStimulus(1, 0, 0, 0, 8'h00);
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkOutput("t3_vec_inv", 32'(lastVec), 32'hFE);
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("t3_vec_next", 32'(lastVec), 32'hB8);

        // Asynchronous reset mid-run, then a clean restart.
        applyStimulus(0, 1, 0, 0, 8'h00);
        resetDut();
        checkOutput("t4_sig", 32'(signature), 32'h00);
        checkOutput("t4_count", 32'(pattern_count), 32'd0);
        checkOutput("t4_vec", 32'(test_vector), 32'h01);
        applyStimulus(1, 0, 0, 0, 8'h00);
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("t4_restart_vec", 32'(lastVec), 32'h01);

        // Counter saturation, then init racing running.
        for (int k = 0; k < 20; k++) applyStimulus(0, 1, 0, 0, 8'h00);
        #1;
        checkOutput("t5_sat", 32'(pattern_count), 32'd15);
        applyStimulus(1, 1, 0, 0, 8'h00);
        #1;
        checkOutput("t5_count_clr", 32'(pattern_count), 32'd0);
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("t5_vec_restart", 32'(lastVec), 32'h01);
        checkOutput("t5_armed_valid", 32'(vector_valid), 32'd1);

        // Strobes ignored in IDLE and in DONE.
        resetDut();
        applyStimulus(0, 1, 1, 0, 8'h55);
        checkOutput("t6_idle_valid", 32'(vector_valid), 32'd0);
        applyStimulus(0, 0, 0, 1, 8'h00);
        #1;
        checkOutput("t6_idle_sig", 32'(signature), 32'h00);
        checkOutput("t6_idle_count", 32'(pattern_count), 32'd0);
        checkOutput("t6_idle_rvalid", 32'(result_valid), 32'd0);
        applyStimulus(1, 0, 0, 0, 8'h00);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 1, 8'h00);
        applyStimulus(0, 0, 0, 0, 8'h00);
        applyStimulus(0, 1, 0, 0, 8'h33);
        applyStimulus(0, 1, 0, 1, 8'h00);
        applyStimulus(0, 0, 0, 1, 8'h00);
        #1;
        checkOutput("t6_done_sig", 32'(signature), 32'h5C);
        checkOutput("t6_done_count", 32'(pattern_count), 32'd3);
        checkOutput("t6_done_pass", 32'(pass), 32'd1);
        checkOutput("t6_done_rvalid", 32'(result_valid), 32'd1);

        // Randomized controller behaviour against the model.
        for (int n = 0; n < 400; n++) begin
            logic ri, rr, rt, rf;
            logic [WIDTH-1:0] rx;
            ri = ($urandom % 25) == 0;
            rr = ($urandom % 10) < 6;
            rt = ($urandom % 4) == 0;
            rf = ($urandom % 12) == 0;
            rx = (($urandom % 5) == 0) ? WIDTH'($urandom) : '0;
            applyStimulus(ri, rr, rt, rf, rx);
        end
        resetDut();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
